// File: rtl/single_argmax.sv
// Argmax over OUTPUT_NODES float32 scores: snapshot on start, one compare per cycle,
// result (index, original bit pattern, NaN seen) latched on entry to DONE.
module single_argmax #(
    parameter int OUTPUT_NODES = 10,
    parameter int IDX_W        = 4
) (
    input  logic                         clk,
    input  logic                         rstn,
    input  logic                         start,
    input  logic [OUTPUT_NODES-1:0][31:0] y,
    output logic                         busy,
    output logic                         done,
    output logic [IDX_W-1:0]             class_idx,
    output logic [31:0]                  max_value,
    output logic                         nan_flag
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_SCAN = 2'd1,
        S_DONE = 2'd2
    } state_t;

    localparam logic SINGLE = (OUTPUT_NODES == 1) ? 1'b1 : 1'b0;

    state_t                          r_state;
    state_t                          w_state_nxt;
    logic [OUTPUT_NODES-1:0][31:0]   r_snap;
    logic [IDX_W-1:0]                r_ptr;
    logic [31:0]                     r_best_bits;
    logic [IDX_W-1:0]                r_best_idx;
    logic                            r_best_valid;
    logic                            r_best_nan;
    logic                            r_busy;
    logic                            r_done;
    logic [IDX_W-1:0]                r_class_idx;
    logic [31:0]                     r_max_value;
    logic                            r_nan_flag;

    logic                            w_accept;
    logic                            w_last;
    logic                            w_step;
    logic                            w_load_res;
    logic [31:0]                     w_base_bits;
    logic [IDX_W-1:0]                w_base_idx;
    logic                            w_base_valid;
    logic                            w_base_nan;
    logic [31:0]                     w_cand;
    logic [IDX_W-1:0]                w_cand_idx;
    logic                            w_cand_nan;
    logic                            w_take;
    logic [31:0]                     w_upd_bits;
    logic [IDX_W-1:0]                w_upd_idx;
    logic                            w_upd_valid;
    logic                            w_upd_nan;

    function automatic logic f_is_nan(input logic [31:0] b);
        return (b[30:23] == 8'hFF) && (b[22:0] != 23'd0);
    endfunction

    // Monotonic unsigned key; -0.0 folds onto +0.0 so signed zeros tie.
    function automatic logic [31:0] f_key(input logic [31:0] b);
        if (b == 32'h8000_0000) begin
            return 32'h8000_0000;
        end else if (b[31]) begin
            return ~b;
        end else begin
            return b ^ 32'h8000_0000;
        end
    endfunction

    // Single comparator: seeds from y[0] on acceptance, then walks the snapshot.
    always_comb begin
        w_accept = start && (r_state != S_SCAN);
        w_last   = (r_ptr == IDX_W'(OUTPUT_NODES - 1));
        if (r_state == S_SCAN) begin
            w_base_bits  = r_best_bits;
            w_base_idx   = r_best_idx;
            w_base_valid = r_best_valid;
            w_base_nan   = r_best_nan;
            w_cand       = r_snap[r_ptr];
            w_cand_idx   = r_ptr;
        end else begin
            w_base_bits  = 32'h0000_0000;
            w_base_idx   = {IDX_W{1'b0}};
            w_base_valid = 1'b0;
            w_base_nan   = 1'b0;
            w_cand       = y[0];
            w_cand_idx   = {IDX_W{1'b0}};
        end
        w_cand_nan = f_is_nan(w_cand);
        w_take     = !w_cand_nan && (!w_base_valid || (f_key(w_cand) > f_key(w_base_bits)));
        if (w_take) begin
            w_upd_bits  = w_cand;
            w_upd_idx   = w_cand_idx;
            w_upd_valid = 1'b1;
        end else begin
            w_upd_bits  = w_base_bits;
            w_upd_idx   = w_base_idx;
            w_upd_valid = w_base_valid;
        end
        w_upd_nan = w_base_nan | w_cand_nan;
    end

    // Next-state and step/load strobes.
    always_comb begin
        w_state_nxt = r_state;
        w_step      = w_accept || (r_state == S_SCAN);
        w_load_res  = (w_accept && SINGLE) || ((r_state == S_SCAN) && w_last);
        case (r_state)
            S_IDLE, S_DONE: begin
                if (w_accept) begin
                    w_state_nxt = SINGLE ? S_DONE : S_SCAN;
                end else begin
                    w_state_nxt = r_state;
                end
            end
            S_SCAN: begin
                if (w_last) begin
                    w_state_nxt = S_DONE;
                end else begin
                    w_state_nxt = S_SCAN;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // State register with registered status levels.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            r_state <= S_IDLE;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_busy  <= (w_state_nxt == S_SCAN);
            r_done  <= (w_state_nxt == S_DONE);
        end
    end

    // Snapshot, working best and result registers.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            r_snap       <= '{default: 32'h0000_0000};
            r_ptr        <= {IDX_W{1'b0}};
            r_best_bits  <= 32'h0000_0000;
            r_best_idx   <= {IDX_W{1'b0}};
            r_best_valid <= 1'b0;
            r_best_nan   <= 1'b0;
            r_class_idx  <= {IDX_W{1'b0}};
            r_max_value  <= 32'h0000_0000;
            r_nan_flag   <= 1'b0;
        end else begin
            if (w_accept) begin
                r_snap <= y;
            end
            if (w_step) begin
                r_best_bits  <= w_upd_bits;
                r_best_idx   <= w_upd_idx;
                r_best_valid <= w_upd_valid;
                r_best_nan   <= w_upd_nan;
                r_ptr        <= w_accept ? IDX_W'(1) : (r_ptr + IDX_W'(1));
            end
            if (w_load_res) begin
                r_class_idx <= w_upd_idx;
                r_max_value <= w_upd_valid ? w_upd_bits : 32'h7FC0_0000;
                r_nan_flag  <= w_upd_nan;
            end
        end
    end

    assign busy      = r_busy;
    assign done      = r_done;
    assign class_idx = r_class_idx;
    assign max_value = r_max_value;
    assign nan_flag  = r_nan_flag;

endmodule

// File: tb/tb_single_argmax.sv
// Directed bench for single_argmax: a 10-node instance and a 1-node instance.
module tb_single_argmax;

    logic              clk = 1'b0;
    logic              rstn;
    logic              start;
    logic [9:0][31:0]  y;
    logic              busy, done, nan_flag;
    logic [3:0]        class_idx;
    logic [31:0]       max_value;

    logic              start1;
    logic [0:0][31:0]  y1;
    logic              busy1, done1, nan_flag1;
    logic [0:0]        class_idx1;
    logic [31:0]       max_value1;

    int n_tests = 0;
    int n_fail  = 0;

    single_argmax #(.OUTPUT_NODES(10), .IDX_W(4)) u_dut (
        .clk(clk), .rstn(rstn), .start(start), .y(y),
        .busy(busy), .done(done), .class_idx(class_idx),
        .max_value(max_value), .nan_flag(nan_flag)
    );

    single_argmax #(.OUTPUT_NODES(1), .IDX_W(1)) u_dut1 (
        .clk(clk), .rstn(rstn), .start(start1), .y(y1),
        .busy(busy1), .done(done1), .class_idx(class_idx1),
        .max_value(max_value1), .nan_flag(nan_flag1)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_all(input logic [31:0] v);
        for (int i = 0; i < 10; i++) y[i] = v;
    endtask

    // Start high for one cycle (T); returns in cycle T+1.
    task automatic do_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic wait_cycles(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic test_reset();
        rstn = 1'b0; start = 1'b0; start1 = 1'b0;
        set_all(32'h0); y1[0] = 32'h0;
        wait_cycles(2);
        rstn = 1'b1;
        n_tests++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy got %0b want 0", busy); end
        n_tests++; if (done !== 1'b0) begin n_fail++; $display("FAIL reset_done got %0b want 0", done); end
        n_tests++; if (class_idx !== 4'd0) begin n_fail++; $display("FAIL reset_idx got %0d want 0", class_idx); end
        n_tests++; if (max_value !== 32'h0) begin n_fail++; $display("FAIL reset_max got %h want 0", max_value); end
        n_tests++; if (nan_flag !== 1'b0) begin n_fail++; $display("FAIL reset_nan got %0b want 0", nan_flag); end
        n_tests++; if (done1 !== 1'b0) begin n_fail++; $display("FAIL reset_done1 got %0b want 0", done1); end
        tick();
        n_tests++; if (busy !== 1'b0 || done !== 1'b0) begin n_fail++; $display("FAIL idle_hold got busy=%0b done=%0b want 0/0", busy, done); end
    endtask

    task automatic test_basic();
        set_all(32'h3F80_0000);
        y[7] = 32'h4000_0000;
        do_start();
        for (int k = 1; k <= 9; k++) begin
            n_tests++; if (busy !== 1'b1 || done !== 1'b0) begin n_fail++; $display("FAIL basic_busy T+%0d got busy=%0b done=%0b want 1/0", k, busy, done); end
            tick();
        end
        n_tests++; if (done !== 1'b1 || busy !== 1'b0) begin n_fail++; $display("FAIL basic_done got done=%0b busy=%0b want 1/0", done, busy); end
        n_tests++; if (class_idx !== 4'd7) begin n_fail++; $display("FAIL basic_idx got %0d want 7", class_idx); end
        n_tests++; if (max_value !== 32'h4000_0000) begin n_fail++; $display("FAIL basic_max got %h want 40000000", max_value); end
        n_tests++; if (nan_flag !== 1'b0) begin n_fail++; $display("FAIL basic_nan got %0b want 0", nan_flag); end
        wait_cycles(3);
        n_tests++; if (done !== 1'b1 || class_idx !== 4'd7) begin n_fail++; $display("FAIL basic_hold got done=%0b idx=%0d want 1/7", done, class_idx); end
    endtask

    task automatic test_neg_tie();
        set_all(32'hC000_0000);
        y[3] = 32'hBF80_0000;
        y[8] = 32'hBF80_0000;
        do_start();
        wait_cycles(9);
        n_tests++; if (done !== 1'b1) begin n_fail++; $display("FAIL neg_done got %0b want 1", done); end
        n_tests++; if (class_idx !== 4'd3) begin n_fail++; $display("FAIL neg_idx got %0d want 3", class_idx); end
        n_tests++; if (max_value !== 32'hBF80_0000) begin n_fail++; $display("FAIL neg_max got %h want bf800000", max_value); end
        n_tests++; if (nan_flag !== 1'b0) begin n_fail++; $display("FAIL neg_nan got %0b want 0", nan_flag); end
    endtask

    task automatic test_zero_nan();
        set_all(32'hBF80_0000);
        y[0] = 32'h8000_0000;
        y[1] = 32'h0000_0000;
        y[2] = 32'h7FC0_0000;
        do_start();
        wait_cycles(9);
        n_tests++; if (class_idx !== 4'd0) begin n_fail++; $display("FAIL zero_idx got %0d want 0", class_idx); end
        n_tests++; if (max_value !== 32'h8000_0000) begin n_fail++; $display("FAIL zero_max got %h want 80000000", max_value); end
        n_tests++; if (nan_flag !== 1'b1) begin n_fail++; $display("FAIL zero_nan got %0b want 1", nan_flag); end
        set_all(32'h7FC0_0000);
        do_start();
        wait_cycles(9);
        n_tests++; if (done !== 1'b1) begin n_fail++; $display("FAIL allnan_done got %0b want 1", done); end
        n_tests++; if (class_idx !== 4'd0) begin n_fail++; $display("FAIL allnan_idx got %0d want 0", class_idx); end
        n_tests++; if (max_value !== 32'h7FC0_0000) begin n_fail++; $display("FAIL allnan_max got %h want 7fc00000", max_value); end
        n_tests++; if (nan_flag !== 1'b1) begin n_fail++; $display("FAIL allnan_nan got %0b want 1", nan_flag); end
    endtask

    task automatic test_snapshot();
        set_all(32'h3F80_0000);
        y[7] = 32'h4000_0000;
        do_start();
        y[5] = 32'h7F80_0000;
        wait_cycles(3);
        start = 1'b1;
        tick();
        start = 1'b0;
        wait_cycles(4);
        n_tests++; if (done !== 1'b0 || busy !== 1'b1) begin n_fail++; $display("FAIL snap_t9 got done=%0b busy=%0b want 0/1", done, busy); end
        tick();
        n_tests++; if (done !== 1'b1) begin n_fail++; $display("FAIL snap_done got %0b want 1", done); end
        n_tests++; if (class_idx !== 4'd7) begin n_fail++; $display("FAIL snap_idx got %0d want 7", class_idx); end
        n_tests++; if (max_value !== 32'h4000_0000) begin n_fail++; $display("FAIL snap_max got %h want 40000000", max_value); end
        do_start();
        n_tests++; if (done !== 1'b0 || busy !== 1'b1) begin n_fail++; $display("FAIL restart got done=%0b busy=%0b want 0/1", done, busy); end
        n_tests++; if (class_idx !== 4'd7) begin n_fail++; $display("FAIL restart_hold got %0d want 7", class_idx); end
        wait_cycles(9);
        n_tests++; if (done !== 1'b1) begin n_fail++; $display("FAIL inf_done got %0b want 1", done); end
        n_tests++; if (class_idx !== 4'd5) begin n_fail++; $display("FAIL inf_idx got %0d want 5", class_idx); end
        n_tests++; if (max_value !== 32'h7F80_0000) begin n_fail++; $display("FAIL inf_max got %h want 7f800000", max_value); end
    endtask

    task automatic test_single();
        y1[0] = 32'h3F00_0000;
        start1 = 1'b1;
        tick();
        start1 = 1'b0;
        n_tests++; if (done1 !== 1'b1 || busy1 !== 1'b0) begin n_fail++; $display("FAIL n1_done got done=%0b busy=%0b want 1/0", done1, busy1); end
        n_tests++; if (class_idx1 !== 1'b0) begin n_fail++; $display("FAIL n1_idx got %0d want 0", class_idx1); end
        n_tests++; if (max_value1 !== 32'h3F00_0000) begin n_fail++; $display("FAIL n1_max got %h want 3f000000", max_value1); end
        n_tests++; if (nan_flag1 !== 1'b0) begin n_fail++; $display("FAIL n1_nan got %0b want 0", nan_flag1); end
    endtask

    task automatic test_reset_midscan();
        set_all(32'h3F80_0000);
        y[2] = 32'h4040_0000;
        do_start();
        wait_cycles(3);
        rstn = 1'b0;
        tick();
        rstn = 1'b1;
        n_tests++; if (busy !== 1'b0 || done !== 1'b0) begin n_fail++; $display("FAIL rst_mid got busy=%0b done=%0b want 0/0", busy, done); end
        n_tests++; if (class_idx !== 4'd0 || max_value !== 32'h0 || nan_flag !== 1'b0) begin n_fail++; $display("FAIL rst_mid_res got idx=%0d max=%h nan=%0b want 0/0/0", class_idx, max_value, nan_flag); end
        n_tests++; if (done1 !== 1'b0 || max_value1 !== 32'h0) begin n_fail++; $display("FAIL rst_mid_n1 got done=%0b max=%h want 0/0", done1, max_value1); end
        tick();
        n_tests++; if (busy !== 1'b0 || done !== 1'b0) begin n_fail++; $display("FAIL rst_idle got busy=%0b done=%0b want 0/0", busy, done); end
        do_start();
        wait_cycles(8);
        n_tests++; if (done !== 1'b0) begin n_fail++; $display("FAIL rst_rescan_early got done=%0b want 0", done); end
        tick();
        n_tests++; if (done !== 1'b1 || class_idx !== 4'd2 || max_value !== 32'h4040_0000) begin n_fail++; $display("FAIL rst_rescan got done=%0b idx=%0d max=%h want 1/2/40400000", done, class_idx, max_value); end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_neg_tie();
        test_zero_nan();
        test_snapshot();
        test_single();
        test_reset_midscan();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
